field_loader: RTL

FIELD_LOADER -- requirements
Module: field_loader

---
 rtl/field_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/field_loader.sv
// Copies a FIELD_W x FIELD_H config ROM into field memory, row-major, one cell per accepted write; latency N+2 cycles from start at full rate.
// Backpressure: a single registered write stage holds address/data and stalls the scan while i_wr_ready is low.
module field_loader #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 32,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
  input  logic                  i_rom_cell_state,
  output logic                  o_wr_en,
  output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
  output logic                  o_wr_cell_state,
  input  logic                  i_wr_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t                  state;
  logic [X_ADR_SIZE-1:0]   x_cnt;
  logic [Y_ADR_SIZE-1:0]   y_cnt;
  logic                    advance;
  logic                    last_cell;

  // The write stage can take a new cell if it is empty or draining this cycle.
  assign advance     = !o_wr_en || i_wr_ready;
  assign last_cell   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign o_rom_x_adr = x_cnt;
  assign o_rom_y_adr = y_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      x_cnt           <= '0;
      y_cnt           <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_wr_en         <= 1'b0;
      o_wr_x_adr      <= '0;
      o_wr_y_adr      <= '0;
      o_wr_cell_state <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= SCAN;
            o_busy <= 1'b1;
            x_cnt  <= '0;
            y_cnt  <= '0;
          end
        end
        SCAN: begin
          if (advance) begin
            o_wr_en         <= 1'b1;
            o_wr_x_adr      <= x_cnt;
            o_wr_y_adr      <= y_cnt;
            o_wr_cell_state <= i_rom_cell_state;
            // Counters park on the final cell so the ROM address stays in range.
            if (last_cell) begin
              state <= DRAIN;
            end else if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + Y_ADR_SIZE'(1);
            end else begin
              x_cnt <= x_cnt + X_ADR_SIZE'(1);
            end
          end
        end
        DRAIN: begin
          if (o_wr_en && i_wr_ready) begin
            o_wr_en <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          x_cnt <= '0;
          y_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
